// File: rtl/tick_counter_pkg.sv
// Shared types and helpers for the prescaled up/down tick counter.
package tick_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Loads above the count range are clamped to the upper bound.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: fires a tick every div+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc;

  // If div drops below presc, presc free-runs to all-ones and wraps before matching.
  assign tick = en && (presc == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Prescaled up/down event counter with wrap/saturate, compare match and overflow report.
// Optional count snapshot register enabled by defining TICK_COUNTER_SNAPSHOT_EN.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int              WIDTH      = 8,
  parameter longint unsigned MAX_VAL    = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat_mode,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  ovf_clr,
  input  logic [WIDTH-1:0]      cmp_val,
`ifdef TICK_COUNTER_SNAPSHOT_EN
  input  logic                  snap,
  output logic [WIDTH-1:0]      snap_val,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  step,
  output logic                  tc,
  output logic                  ovf,
  output logic                  match
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
    $error("tick_counter: WIDTH must be in 1..32");
  end
  if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_max_chk
    $error("tick_counter: MAX_VAL must be below 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [31:0]      MAX_32 = 32'(MAX_VAL);

  dir_e             dir;
  mode_e            mode;
  logic             tick;
  logic             tick_eff;
  logic             at_bound;
  logic             boundary;
  logic [WIDTH-1:0] count_nxt;

  assign dir  = dir_e'(up);
  assign mode = mode_e'(sat_mode);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clear | load),
    .div   (div),
    .tick  (tick)
  );

  assign tick_eff = tick & ~clear & ~load;
  assign at_bound = (dir == DIR_UP) ? (count == MAX_C) : (count == '0);
  assign boundary = tick_eff & at_bound;

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = WIDTH'(clamp_load(32'(load_val), MAX_32));
    end else if (tick_eff) begin
      if (dir == DIR_UP) begin
        count_nxt = at_bound ? ((mode == MODE_SAT) ? MAX_C : '0) : count + WIDTH'(1);
      end else begin
        count_nxt = at_bound ? ((mode == MODE_SAT) ? '0 : MAX_C) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      step  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      step  <= tick_eff;
      tc    <= boundary;
    end
  end

  // A boundary hit in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (boundary) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign match = (count == cmp_val);

`ifdef TICK_COUNTER_SNAPSHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_val <= '0;
    end else if (snap) begin
      snap_val <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter: directed scenarios plus randomized traffic against a reference model.
module tb_tick_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = 9;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             sat_mode = 1'b0;
  logic [PW-1:0]    div = '0;
  logic             clear = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             ovf_clr = 1'b0;
  logic [WIDTH-1:0] cmp_val = 8'd200;
  logic             snap = 1'b0;
  logic [WIDTH-1:0] count;
  logic             step, tc, ovf, match;
`ifdef TICK_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_val;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tick_counter #(
    .WIDTH      (WIDTH),
    .MAX_VAL    (MAXV),
    .PRESCALE_W (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .sat_mode (sat_mode),
    .div      (div),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
    .cmp_val  (cmp_val),
`ifdef TICK_COUNTER_SNAPSHOT_EN
    .snap     (snap),
    .snap_val (snap_val),
`endif
    .count    (count),
    .step     (step),
    .tc       (tc),
    .ovf      (ovf),
    .match    (match)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model: count as a plain integer in 0..MAXV.
  typedef struct {
    int count;
    int presc;
    bit ovf;
    bit step;
    bit tc;
    int snap;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t s, bit i_en, bit i_up, bit i_sat, bit i_clear,
                                        bit i_load, bit i_ovf_clr, bit i_snap, int i_div,
                                        int i_load_val);
    model_t n = s;
    bit fire = i_en && (s.presc == i_div);
    int raw;
    bit out_of_range;
    n.step = 0;
    n.tc   = 0;
    if (i_clear || i_load) n.presc = 0;
    else if (i_en) n.presc = fire ? 0 : (s.presc + 1) % (1 << PW);
    if (i_clear) begin
      n.count = 0;
      n.ovf   = 0;
    end else if (i_load) begin
      n.count = (i_load_val > MAXV) ? MAXV : i_load_val;
      if (i_ovf_clr) n.ovf = 0;
    end else begin
      if (fire) begin
        raw = s.count + (i_up ? 1 : -1);
        out_of_range = (raw < 0) || (raw > MAXV);
        n.step = 1;
        n.tc   = out_of_range;
        if (!out_of_range) n.count = raw;
        else if (i_sat)    n.count = s.count;
        else               n.count = (raw + MAXV + 1) % (MAXV + 1);
      end
      if (n.tc) n.ovf = 1;
      else if (i_ovf_clr) n.ovf = 0;
    end
    if (i_snap) n.snap = n.count;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)
      m <= '{0, 0, 0, 0, 0, 0};
    else
      m <= model_next(m, en, up, sat_mode, clear, load, ovf_clr, snap, int'(div), int'(load_val));
  end

  always @(negedge clk) begin
    chk("m_count", count, m.count);
    chk("m_step", step, m.step);
    chk("m_tc", tc, m.tc);
    chk("m_ovf", ovf, m.ovf);
    chk("m_match", match, m.count == int'(cmp_val));
`ifdef TICK_COUNTER_SNAPSHOT_EN
    chk("m_snap_val", snap_val, m.snap);
`endif
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1; up = 1'b1; sat_mode = 1'b0; div = '0;
    #20 reset = 1'b0;

    // Wrap up through MAXV
    for (int k = 1; k <= 12; k++) begin
      step_cyc();
      chk("wrap_count", count, k % 10);
      chk("wrap_tc", tc, (k == 10) ? 1 : 0);
    end
    chk("wrap_ovf", ovf, 1);

    // Saturate up
    clear = 1'b1; sat_mode = 1'b1;
    step_cyc();
    chk("clr_count", count, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_step", step, 0);
    clear = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step_cyc();
      chk("sat_count", count, (k < 9) ? k : 9);
      chk("sat_tc", tc, (k >= 10) ? 1 : 0);
      chk("sat_step", step, 1);
    end

    // Divider and enable freeze
    clear = 1'b1; sat_mode = 1'b0; div = 4'd3;
    step_cyc();
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step_cyc();
      chk("div_count", count, k / 4);
    end
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step_cyc();
      chk("frozen_count", count, 2);
      chk("frozen_step", step, 0);
    end
    en = 1'b1;
    step_cyc();
    chk("resume1_count", count, 2);
    step_cyc();
    chk("resume2_count", count, 3);
    chk("resume2_step", step, 1);

    // Underflow wrap, then clamped load
    clear = 1'b1; div = '0; up = 1'b0;
    step_cyc();
    clear = 1'b0;
    step_cyc();
    chk("under_count", count, 9);
    chk("under_tc", tc, 1);
    chk("under_ovf", ovf, 1);
    load = 1'b1; load_val = 8'd200;
    step_cyc();
    load = 1'b0;
    chk("load_count", count, 9);
    chk("load_tc", tc, 0);
    chk("load_step", step, 0);

    // clear and load together with a tick pending
    clear = 1'b1; load = 1'b1; load_val = 8'd5;
    step_cyc();
    clear = 1'b0; load = 1'b0;
    chk("cl_count", count, 0);
    chk("cl_ovf", ovf, 0);
    chk("cl_step", step, 0);
    chk("cl_tc", tc, 0);

    // Asynchronous reset mid-count
    up = 1'b1;
    step_cyc(); step_cyc(); step_cyc();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_step", step, 0);
    chk("async_tc", tc, 0);
    chk("async_ovf", ovf, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Compare match and snapshot
    load = 1'b1; load_val = 8'd5; cmp_val = 8'd7;
    step_cyc();
    load = 1'b0;
    chk("pre_snap_count", count, 5);
    chk("pre_snap_match", match, 0);
    snap = 1'b1;
    step_cyc();
    snap = 1'b0;
    chk("snap_count", count, 6);
`ifdef TICK_COUNTER_SNAPSHOT_EN
    chk("snap_val_a", snap_val, 6);
`endif
    step_cyc();
    chk("match_at7", match, 1);
`ifdef TICK_COUNTER_SNAPSHOT_EN
    chk("snap_val_b", snap_val, 6);
`endif
    step_cyc();
    chk("match_at8", match, 0);

    // Randomized traffic, checked by the model on every negedge
    for (int i = 0; i < 3000; i++) begin
      step_cyc();
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 39) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(0, 49) == 0) div = PW'($urandom_range(0, 5));
      clear    = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 31) == 0);
      load_val = WIDTH'($urandom_range(0, 255));
      ovf_clr  = ($urandom_range(0, 15) == 0);
      cmp_val  = WIDTH'($urandom_range(0, 11));
      snap     = ($urandom_range(0, 7) == 0);
    end

    step_cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
